dosing_sequencer: RTL

Sequences the three dispensing motors from the R, G and B cycle counts held in the RGB memory. It sits between the keypad/RGB-memory path and the motor outputs. On a start request it runs motor R for `ciclos_R` time units, then G, then B, with exactly one motor on at a time. It then pulses `done` and a memory-clear request. A time unit is `TICK_DIV` pulses of the shared slow strobe, so one unit is 400 ms when the strobe is 100 ms.

---
 rtl/dosing_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dosing_sequencer.sv
// Runs dispensing motors R, G, B one after another for their latched unit counts.
// One unit is TICK_DIV pulses of the shared slow tick strobe.
module dosing_sequencer #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic             ready_in,
    input  logic [CNT_W-1:0] ciclos_R,
    input  logic [CNT_W-1:0] ciclos_G,
    input  logic [CNT_W-1:0] ciclos_B,
    output logic [2:0]       Motores,
    output logic             busy,
    output logic [2:0]       flags,
    output logic             done,
    output logic             clear_mem,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRunR,
        StRunG,
        StRunB,
        StFinish
    } state_e;

    localparam logic [3:0] PrescMax = 4'(TICK_DIV - 1);

    state_e           r_state;
    logic             r_start_low;
    logic [CNT_W-1:0] r_cnt_r;
    logic [CNT_W-1:0] r_cnt_g;
    logic [CNT_W-1:0] r_cnt_b;
    logic [CNT_W-1:0] r_units;
    logic [3:0]       r_presc;

    logic             w_start_edge;
    logic [2:0]       w_nonzero;
    logic [2:0]       w_eligible;
    state_e           w_next_chan;
    logic [2:0]       w_next_motor;
    logic [CNT_W-1:0] w_next_units;
    logic             w_to_finish;
    logic             w_unit_wrap;
    logic             w_last_tick;

    // r_start_low resets to 0, so a start level held through reset is never an edge.
    assign w_start_edge = start & r_start_low;
    assign w_nonzero    = {|r_cnt_r, |r_cnt_g, |r_cnt_b};
    assign w_unit_wrap  = tick && (r_presc == PrescMax);
    assign w_last_tick  = w_unit_wrap && (r_units == CNT_W'(1));
    assign w_to_finish  = (w_next_chan == StFinish);
    assign remaining    = r_units;

    // Channels still ahead of the current state, in R, G, B order.
    always_comb begin
        w_eligible = 3'b000;
        case (r_state)
            StLoad:  w_eligible = w_nonzero;
            StRunR:  w_eligible = w_nonzero & 3'b011;
            StRunG:  w_eligible = w_nonzero & 3'b001;
            default: w_eligible = 3'b000;
        endcase

        w_next_chan  = StFinish;
        w_next_motor = 3'b000;
        w_next_units = '0;
        if (w_eligible[2]) begin
            w_next_chan  = StRunR;
            w_next_motor = 3'b100;
            w_next_units = r_cnt_r;
        end else if (w_eligible[1]) begin
            w_next_chan  = StRunG;
            w_next_motor = 3'b010;
            w_next_units = r_cnt_g;
        end else if (w_eligible[0]) begin
            w_next_chan  = StRunB;
            w_next_motor = 3'b001;
            w_next_units = r_cnt_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_start_low <= 1'b0;
            r_cnt_r     <= '0;
            r_cnt_g     <= '0;
            r_cnt_b     <= '0;
            r_units     <= '0;
            r_presc     <= '0;
            Motores     <= 3'b000;
            busy        <= 1'b0;
            flags       <= 3'b000;
            done        <= 1'b0;
            clear_mem   <= 1'b0;
        end else begin
            r_start_low <= ~start;
            done        <= 1'b0;
            clear_mem   <= 1'b0;
            if (abort && (r_state != StIdle)) begin
                r_state <= StIdle;
                Motores <= 3'b000;
                busy    <= 1'b0;
                r_units <= '0;
                r_presc <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_start_edge && ready_in) begin
                            r_cnt_r <= ciclos_R;
                            r_cnt_g <= ciclos_G;
                            r_cnt_b <= ciclos_B;
                            flags   <= 3'b000;
                            busy    <= 1'b1;
                            r_state <= StLoad;
                        end
                    end
                    StLoad: begin
                        flags     <= ~w_nonzero;
                        r_state   <= w_next_chan;
                        Motores   <= w_next_motor;
                        r_units   <= w_next_units;
                        r_presc   <= '0;
                        done      <= w_to_finish;
                        clear_mem <= w_to_finish;
                    end
                    StRunR, StRunG, StRunB: begin
                        if (w_last_tick) begin
                            flags     <= flags | Motores;
                            r_state   <= w_next_chan;
                            Motores   <= w_next_motor;
                            r_units   <= w_next_units;
                            r_presc   <= '0;
                            done      <= w_to_finish;
                            clear_mem <= w_to_finish;
                        end else if (w_unit_wrap) begin
                            r_presc <= '0;
                            r_units <= r_units - CNT_W'(1);
                        end else if (tick) begin
                            r_presc <= r_presc + 4'd1;
                        end
                    end
                    StFinish: begin
                        r_state <= StIdle;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                        Motores <= 3'b000;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
